nios_buttons_in: RTL and testbench
==================================

Name: nios_buttons_in

Overview:
- Avalon-MM slave input PIO: the read-side counterpart of the 4-bit LED output port.
- Samples board push-buttons and exposes their debounced level to the Nios II CPU.
- Latches per-bit edge events and raises a maskable level interrupt.
- Sits on the same system interconnect, same clock domain as the CPU data master.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive cycles a synchronized change must persist before acceptance; 0 or 1 = no filtering (accept after 1 cycle).
- EDGE_TYPE, 1, captured edge: 0 rising, 1 falling, 2 any.
- IDLE_LEVEL, 1, reset value of synchronizer/stable bits; buttons are active-low.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset; asynchronous, active-low.
- address  input  2  word register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  read data, zero-extended above WIDTH.
- in_port  input  WIDTH  raw asynchronous button inputs.
- irq  output  1  level interrupt request, active-high.

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset_n` is asynchronous, active-low. All flops reset on it.
- Register map (word addresses):
  - 0 DATA: RO, debounced levels; writes ignored.
  - 1 DIRECTION: reads 0, writes ignored.
  - 2 IRQ_MASK: RW, WIDTH bits.
  - 3 EDGE_CAPTURE: read returns captured bits; write is write-1-to-clear per bit.
- Read path: zero wait states, read latency 0. `readdata` is a combinational mux on `address` of registered state. Reads have no side effects.
- Write qualifier: chipselect && !write_n.
- Synchronizer: two flops per bit (s1, s2), reset to IDLE_LEVEL.
- Debounce, per bit:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - While s2 != stable: counter increments. When counter == DEBOUNCE_CYCLES-1, stable <= s2 and counter <= 0.
  - While s2 == stable: counter <= 0. A glitch shorter than DEBOUNCE_CYCLES is therefore discarded.
  - DEBOUNCE_CYCLES <= 1: stable <= s2 every cycle.
  - stable resets to IDLE_LEVEL; counters reset to 0.
- Edge detect:
  - stable_d <= stable every cycle; reset IDLE_LEVEL.
  - event = rising (stable & ~stable_d), falling (~stable & stable_d) or both, per EDGE_TYPE.
- EDGE_CAPTURE: bit sets on event and holds until cleared.
  - Set and clear on the same bit in the same cycle: set wins, so no event is lost.
  - Clears on bits with no event take effect.
- Latency: in_port change to DATA = 2 + max(DEBOUNCE_CYCLES,1) clock edges. EDGE_CAPTURE sets one edge later.
- irq = |(EDGE_CAPTURE & IRQ_MASK), from registers, no combinational path from the bus.
  - Writing the mask with capture bits already pending asserts irq the next cycle.
- Reset values: IRQ_MASK 0, EDGE_CAPTURE 0, irq 0, DATA reads IDLE_LEVEL.
- Reset asserted mid-debounce: counters clear. After release, a held button must qualify for the full window again.
- Reset never produces a capture event, because stable and stable_d both reset to IDLE_LEVEL.

Decomposition:
- Shared package holds:
  - register address constants ADDR_DATA=0, ADDR_DIR=1, ADDR_MASK=2, ADDR_EDGE=3;
  - EDGE_TYPE encodings EDGE_RISE, EDGE_FALL, EDGE_ANY.
- One natural sub-module: `nios_debounce_bit` (2-flop sync + counter + stable register, parameterized by DEBOUNCE_CYCLES and IDLE_LEVEL), instantiated WIDTH times via generate.
- Register file, edge logic and read mux stay in the top module.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1, IDLE_LEVEL=1):
- Reset, then read addr 0/1/2/3 -> 0xF, 0x0, 0x0, 0x0; irq=0 throughout.
- Drive in_port 0xF->0xE and hold -> DATA reads 0xE exactly 6 edges after the change; EDGE_CAPTURE reads 0x1 on edge 7; irq stays 0 (mask 0).
- Write MASK=0x1 with capture 0x1 pending -> irq=1 next cycle. Write EDGE_CAPTURE=0x1 -> capture 0x0, irq=0 next cycle.
- Glitch: bit 2 low for 3 cycles then high -> DATA stays 0xF, EDGE_CAPTURE stays 0x0.
- Write EDGE_CAPTURE=0x2 in the same cycle bit 1's falling event registers -> bit 1 reads 1 afterwards (set wins).
- Hold bit 3 low, assert reset_n low after 2 qualifying cycles, release -> no capture. Bit 3 reaches DATA only after a full 2+4-edge window post-reset; capture 0x8 follows one edge later.

Source files
------------

// File: rtl/nios_buttons_in_pkg.sv
// Shared constants for the push-button input PIO: register map and edge-type encodings.
package nios_buttons_in_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_DIR  = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } reg_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_debounce_bit.sv
// One button bit: two-flop synchronizer followed by a persistence-counter debouncer.
module nios_debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic s1_q, s2_q;
  logic stable_q, stable_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= IDLE_LEVEL;
      s2_q     <= IDLE_LEVEL;
      stable_q <= IDLE_LEVEL;
    end else begin
      s1_q     <= din;
      s2_q     <= s1_q;
      stable_q <= stable_d;
    end
  end

  if (DEBOUNCE_CYCLES <= 1) begin : g_direct
    assign stable_d = s2_q;
  end else begin : g_filter
    localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: defaults come first so every path assigns each output and no latch is inferred.
    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (s2_q != stable_q) begin
        if (cnt_q == LAST) stable_d = s2_q;
        else               cnt_d    = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/nios_buttons_in.sv
// Avalon-MM input PIO for board push-buttons: debounced DATA, IRQ mask and
// write-1-to-clear edge capture driving a level interrupt.
module nios_buttons_in
  import nios_buttons_in_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = EDGE_FALL,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IDLE_VEC = (IDLE_LEVEL != 0) ? '1 : '0;

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_dly_q, stable_dly_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] edge_event, edge_clear;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_VEC[i])
    ) u_debounce (
      .clk   (clk),
      .rst_n (reset_n),
      .din   (in_port[i]),
      .dout  (stable[i])
    );
  end

  if (WIDTH < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  assign wr_en = chipselect && !write_n;

  always_comb begin
    stable_dly_d = stable;
    mask_d       = mask_q;
    edge_clear   = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_event = stable & ~stable_dly_q;
      EDGE_FALL: edge_event = ~stable & stable_dly_q;
      default:   edge_event = stable ^ stable_dly_q;
    endcase
    if (wr_en && address == ADDR_MASK) mask_d     = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGE) edge_clear = writedata[WIDTH-1:0];
    // A new event on a bit overrides a simultaneous clear so no press is lost.
    edge_d = (edge_q & ~edge_clear) | edge_event;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_dly_q <= IDLE_VEC;
      mask_q       <= '0;
      edge_q       <= '0;
    end else begin
      stable_dly_q <= stable_dly_d;
      mask_q       <= mask_d;
      edge_q       <= edge_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (reg_addr_e'(address))
      ADDR_DATA: readdata[WIDTH-1:0] = stable;
      ADDR_DIR:  readdata            = '0;
      ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_q;
      default:   readdata            = '0;
    endcase
  end

  assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_nios_buttons_in.sv
// Scoreboard bench for nios_buttons_in: reads push expectations, a negedge monitor pops and compares.
module tb_nios_buttons_in;
  import nios_buttons_in_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;
  logic        rd_req;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  nios_buttons_in #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .EDGE_TYPE       (EDGE_FALL),
    .IDLE_LEVEL      (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'd0;
    rd_req     = 1'b0;
  endtask

  task automatic cyc_idle();
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic cyc_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus_idle();
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
  endtask

  task automatic cyc_read(input logic [1:0] a, input logic [31:0] d, input logic i, input string nm);
    exp_t e;
    @(posedge clk); #1;
    bus_idle();
    chipselect = 1'b1;
    address    = a;
    rd_req     = 1'b1;
    e.name = nm;
    e.data = d;
    e.irq  = i;
    exp_q.push_back(e);
  endtask

  // Monitor: every presented read is compared against the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rd_req) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL orphan_read: readdata=%h with no expectation queued", readdata);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (readdata !== e.data) begin
          bad++;
          $display("FAIL %s: readdata=%h expected=%h", e.name, readdata, e.data);
        end
        total++;
        if (irq !== e.irq) begin
          bad++;
          $display("FAIL %s_irq: irq=%b expected=%b", e.name, irq, e.irq);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    in_port = 4'hF;
    bus_idle();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state and ignored writes.
    cyc_read(ADDR_DATA, 32'hF, 1'b0, "rst_data");
    cyc_read(ADDR_DIR,  32'h0, 1'b0, "rst_dir");
    cyc_read(ADDR_MASK, 32'h0, 1'b0, "rst_mask");
    cyc_read(ADDR_EDGE, 32'h0, 1'b0, "rst_edge");
    cyc_write(ADDR_DATA, 32'h0);
    cyc_write(ADDR_DIR,  32'hFFFF_FFFF);
    cyc_read(ADDR_DATA, 32'hF, 1'b0, "data_ro");
    cyc_read(ADDR_DIR,  32'h0, 1'b0, "dir_zero");

    // Bit 0 press: DATA changes exactly 6 edges later, capture on edge 7.
    in_port = 4'hE;
    for (int k = 1; k <= 5; k++) cyc_read(ADDR_DATA, 32'hF, 1'b0, "press0_early");
    cyc_read(ADDR_DATA, 32'hE, 1'b0, "press0_data");
    cyc_read(ADDR_EDGE, 32'h1, 1'b0, "press0_edge");

    // Mask with pending capture raises irq; W1C clears it.
    cyc_write(ADDR_MASK, 32'h1);
    cyc_read(ADDR_MASK, 32'h1, 1'b1, "mask_irq");
    cyc_write(ADDR_EDGE, 32'h1);
    cyc_read(ADDR_EDGE, 32'h0, 1'b0, "w1c_clear");

    // Release bit 0: rising edge is not captured.
    in_port = 4'hF;
    repeat (4) cyc_idle();
    cyc_read(ADDR_DATA, 32'hE, 1'b0, "release0_early");
    cyc_read(ADDR_DATA, 32'hF, 1'b0, "release0_data");
    cyc_read(ADDR_EDGE, 32'h0, 1'b0, "release0_edge");

    // Glitch on bit 2 for 3 cycles is discarded.
    in_port = 4'hB;
    repeat (3) cyc_idle();
    in_port = 4'hF;
    for (int k = 0; k < 8; k++) cyc_read(ADDR_DATA, 32'hF, 1'b0, "glitch_data");
    cyc_read(ADDR_EDGE, 32'h0, 1'b0, "glitch_edge");

    // Clear of bit 1 lands in the same cycle as its falling event: set wins.
    in_port = 4'hD;
    repeat (5) cyc_idle();
    cyc_write(ADDR_EDGE, 32'h2);
    cyc_read(ADDR_EDGE, 32'h2, 1'b0, "set_wins");
    cyc_write(ADDR_MASK, 32'h2);
    cyc_read(ADDR_DATA, 32'hD, 1'b1, "bit1_irq");
    cyc_write(ADDR_EDGE, 32'h2);
    cyc_read(ADDR_EDGE, 32'h0, 1'b0, "bit1_clear");

    in_port = 4'hF;
    repeat (5) cyc_idle();
    cyc_read(ADDR_DATA, 32'hF, 1'b0, "release1_data");
    cyc_read(ADDR_EDGE, 32'h0, 1'b0, "release1_edge");

    // Bit 3 held low, reset mid-debounce: full window required afterwards.
    in_port = 4'h7;
    repeat (4) cyc_idle();
    reset_n = 1'b0;
    repeat (2) cyc_idle();
    reset_n = 1'b1;
    cyc_read(ADDR_MASK, 32'h0, 1'b0, "post_rst_mask");
    cyc_read(ADDR_EDGE, 32'h0, 1'b0, "post_rst_edge");
    repeat (2) cyc_idle();
    cyc_read(ADDR_DATA, 32'hF, 1'b0, "post_rst_early");
    cyc_read(ADDR_DATA, 32'h7, 1'b0, "post_rst_data");
    cyc_read(ADDR_EDGE, 32'h8, 1'b0, "post_rst_capture");
    cyc_write(ADDR_MASK, 32'h8);
    cyc_read(ADDR_EDGE, 32'h8, 1'b1, "bit3_irq");

    cyc_idle();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
